// File: rtl/pea_pkg.sv
// Shared types and defaults for the Pea-side sequencing blocks.
// Holds the kernel-iteration FSM encoding and its default drain length.
package pea_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } k_iter_state_e;

    localparam int K_ITER_DRAIN_DEF = 5;

endpackage

// File: rtl/k_iter_wrap_cnt.sv
// Generic wrap-around counter with enable, clear and programmable limit.
// wrap_o flags that the count sits at the limit, so it wraps on the next enabled step.
module k_iter_wrap_cnt #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_reg <= '0;
        end else if (clr_i) begin
            cnt_reg <= '0;
        end else if (en_i) begin
            cnt_reg <= wrap_o ? '0 : cnt_reg + 1'b1;
        end
    end

    assign wrap_o = (cnt_reg == limit_i);
    assign cnt_o  = cnt_reg;

endmodule

// File: rtl/k_iter_counter.sv
// Kernel iteration sequencer: steps the config address K times per repetition, N repetitions.
// Define K_ITER_PERF_EN to add busy-cycle and stall-cycle performance counters.
module k_iter_counter
    import pea_pkg::*;
#(
    parameter int  N_CFG     = 32,
    parameter int  REP_W     = 16,
    parameter int  DRAIN_CYC = K_ITER_DRAIN_DEF,
    localparam int AW        = $clog2(N_CFG)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic [AW:0]      k_i,
    input  logic [REP_W-1:0] n_rep_i,
    output logic [AW-1:0]    cfg_addr_o,
    output logic [REP_W-1:0] rep_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             last_o,
    output logic             done_o
`ifdef K_ITER_PERF_EN
    ,
    output logic [31:0]      cyc_cnt_o,
    output logic [31:0]      stall_cnt_o
`endif
);

    localparam int            DW         = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);
    localparam logic [AW:0]   K_MAX      = (AW+1)'(N_CFG);

    k_iter_state_e    state_reg;
    logic [AW:0]      k_reg;
    logic [REP_W-1:0] n_reg;
    logic [DW-1:0]    drain_reg;
    logic             done_reg;

    logic [AW:0]      k_sat;
    logic             start_zero;
    logic             is_idle;
    logic             is_run;
    logic             drain_end;
    logic             start_ok;
    logic             issue;
    logic             final_pt;
    logic             addr_wrap;
    logic             rep_wrap;
    logic             cnt_clr;
    logic             addr_en;
    logic             rep_en;
    logic [AW-1:0]    addr_lim;
    logic [REP_W-1:0] rep_lim;

    assign k_sat      = (k_i > K_MAX) ? K_MAX : k_i;
    assign start_zero = (k_sat == '0) || (n_rep_i == '0);

    assign is_idle   = (state_reg == IDLE);
    assign is_run    = (state_reg == RUN);
    assign drain_end = (state_reg == DRAIN) && (drain_reg == '0);

    // A start coinciding with the done cycle is taken just like one seen in IDLE.
    assign start_ok  = start_i && !clear_i && (is_idle || drain_end);

    assign issue    = is_run && !stall_i;
    assign final_pt = addr_wrap && rep_wrap;
    assign addr_lim = AW'(k_reg - 1'b1);
    assign rep_lim  = n_reg - 1'b1;

    // The final issue holds both counters; they clear when the drain completes.
    assign cnt_clr = clear_i || drain_end;
    assign addr_en = issue && !final_pt;
    assign rep_en  = issue && addr_wrap && !final_pt;

    k_iter_wrap_cnt #(.W(AW)) u_addr_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr),
        .en_i    (addr_en),
        .limit_i (addr_lim),
        .cnt_o   (cfg_addr_o),
        .wrap_o  (addr_wrap)
    );

    k_iter_wrap_cnt #(.W(REP_W)) u_rep_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr),
        .en_i    (rep_en),
        .limit_i (rep_lim),
        .cnt_o   (rep_o),
        .wrap_o  (rep_wrap)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            n_reg     <= '0;
            drain_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (clear_i) begin
                state_reg <= IDLE;
                drain_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_ok) begin
                            k_reg <= k_sat;
                            n_reg <= n_rep_i;
                            if (start_zero) done_reg  <= 1'b1;
                            else            state_reg <= RUN;
                        end
                    end
                    RUN: begin
                        if (issue && final_pt) begin
                            state_reg <= DRAIN;
                            drain_reg <= DRAIN_LOAD;
                            // done must be visible in the last drain cycle, hence set one edge early.
                            if (DRAIN_CYC == 1) done_reg <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (drain_reg == '0) begin
                            state_reg <= IDLE;
                            if (start_ok) begin
                                k_reg <= k_sat;
                                n_reg <= n_rep_i;
                                if (start_zero) done_reg  <= 1'b1;
                                else            state_reg <= RUN;
                            end
                        end else begin
                            drain_reg <= drain_reg - 1'b1;
                            if (drain_reg == DW'(1)) done_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign valid_o = issue;
    assign last_o  = issue && final_pt && !clear_i;
    assign busy_o  = !is_idle;
    assign done_o  = done_reg;

`ifdef K_ITER_PERF_EN
    logic [31:0] cyc_reg;
    logic [31:0] stall_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cyc_reg   <= '0;
            stall_reg <= '0;
        end else if (start_ok) begin
            cyc_reg   <= '0;
            stall_reg <= '0;
        end else begin
            if (busy_o && (cyc_reg != '1))            cyc_reg   <= cyc_reg + 1'b1;
            if (is_run && stall_i && (stall_reg != '1)) stall_reg <= stall_reg + 1'b1;
        end
    end

    assign cyc_cnt_o   = cyc_reg;
    assign stall_cnt_o = stall_reg;
`endif

endmodule

// File: tb/tb_k_iter_counter.sv
// Self-checking bench for k_iter_counter: vector table plus hand-written corner sequences.
// Issued addresses are checked against a scoreboard queue filled when each start is driven.
module tb_k_iter_counter;

    localparam int N_CFG = 32;
    localparam int REP_W = 16;
    localparam int AW    = 5;

    logic             clk_i   = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             start_i = 1'b0;
    logic             clear_i = 1'b0;
    logic             stall_i = 1'b0;
    logic [AW:0]      k_i     = '0;
    logic [REP_W-1:0] n_rep_i = '0;
    logic [AW-1:0]    cfg_addr_o;
    logic [REP_W-1:0] rep_o;
    logic             valid_o;
    logic             busy_o;
    logic             last_o;
    logic             done_o;
`ifdef K_ITER_PERF_EN
    logic [31:0]      cyc_cnt_o;
    logic [31:0]      stall_cnt_o;
`endif

    k_iter_counter #(.N_CFG(N_CFG), .REP_W(REP_W), .DRAIN_CYC(5)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (start_i),
        .clear_i    (clear_i),
        .stall_i    (stall_i),
        .k_i        (k_i),
        .n_rep_i    (n_rep_i),
        .cfg_addr_o (cfg_addr_o),
        .rep_o      (rep_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .last_o     (last_o),
        .done_o     (done_o)
`ifdef K_ITER_PERF_EN
        ,
        .cyc_cnt_o  (cyc_cnt_o),
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int addr;
        int rep;
        int last;
    } exp_t;

    typedef struct {
        int k;
        int n;
        int stall_t;
        int stall_len;
        int restart_t;
        int exp_done_t;
        int exp_busy;
        int exp_valid;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    int n_checks = 0;
    int n_errors = 0;
    int done_seen;
    int busy_seen;
    int valid_seen;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic sample();
        exp_t e;
        if (valid_o) begin
            valid_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_valid: got addr=%0d rep=%0d, required no issue",
                         cfg_addr_o, rep_o);
            end else begin
                e = exp_q.pop_front();
                if (int'(cfg_addr_o) != e.addr || int'(rep_o) != e.rep || int'(last_o) != e.last) begin
                    n_errors++;
                    $display("FAIL issue: got addr=%0d rep=%0d last=%0d, required addr=%0d rep=%0d last=%0d",
                             cfg_addr_o, rep_o, last_o, e.addr, e.rep, e.last);
                end
                $display("issue addr=%0d rep=%0d last=%0d", cfg_addr_o, rep_o, last_o);
            end
        end else if (last_o) begin
            chk("last_without_valid", 1, 0);
        end
        if (busy_o) busy_seen++;
        if (done_o) done_seen++;
    endtask

    task automatic step();
        @(negedge clk_i);
        sample();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_seq(input int k, input int n);
        int kk;
        exp_t e;
        kk = (k > N_CFG) ? N_CFG : k;
        for (int r = 0; r < n; r++) begin
            for (int a = 0; a < kk; a++) begin
                e.addr = a;
                e.rep  = r;
                e.last = (r == n - 1 && a == kk - 1) ? 1 : 0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic clear_stats();
        done_seen  = 0;
        busy_seen  = 0;
        valid_seen = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int done_t;
        done_t = -1;
        clear_stats();
        push_seq(v.k, v.n);
        k_i     = (AW+1)'(v.k);
        n_rep_i = REP_W'(v.n);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int t = 1; t <= 300 && done_t < 0; t++) begin
            stall_i = (t >= v.stall_t && t < v.stall_t + v.stall_len);
            start_i = (v.restart_t != 0 && (t == v.restart_t || t == v.restart_t + 2));
            if (start_i) begin
                k_i     = 5;
                n_rep_i = 7;
            end
            step();
            if (done_seen != 0) done_t = t;
        end
        stall_i = 1'b0;
        start_i = 1'b0;
        for (int t = 0; t < 4; t++) step();
        $display("run k=%0d n=%0d: done_t=%0d busy=%0d valid=%0d", v.k, v.n, done_t, busy_seen, valid_seen);
        chk("done_latency", done_t, v.exp_done_t);
        chk("busy_cycles", busy_seen, v.exp_busy);
        chk("valid_cycles", valid_seen, v.exp_valid);
        chk("done_pulses", done_seen, 1);
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_addr"},  cfg_addr_o, 0);
        chk({tag, "_rep"},   rep_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_last"},  last_o, 0);
        chk({tag, "_done"},  done_o, 0);
    endtask

    initial begin
        int t2;
        vec_t v;

        //           k   n  st  sl  rs  done busy valid
        vecs[0] = '{ 3,  2,  0,  0,  0,  11,  11,  6};
        vecs[1] = '{ 4,  1,  2,  2,  0,  11,  11,  4};
        vecs[2] = '{ 0,  5,  0,  0,  0,   1,   0,  0};
        vecs[3] = '{ 3,  0,  0,  0,  0,   1,   0,  0};
        vecs[4] = '{ 2,  3,  0,  0,  2,  11,  11,  6};
        vecs[5] = '{ 1,  4,  0,  0,  0,   9,   9,  4};
        vecs[6] = '{40,  1,  0,  0,  0,  37,  37, 32};
        vecs[7] = '{ 2,  1,  3,  4,  0,   7,   7,  2};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk_quiet("reset");
        rst_n_i = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // clear_i mid-run at address 2, then a full sequence afterwards
        clear_stats();
        push_seq(3, 1);
        exp_q[2].last = 0;
        k_i = 4; n_rep_i = 2; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk_quiet("after_clear");
        for (int t = 0; t < 8; t++) step();
        chk("clear_no_done", done_seen, 0);
        chk("clear_scoreboard", exp_q.size(), 0);
        $display("clear mid-run: busy=%0d valid=%0d", busy_seen, valid_seen);
        v = '{4, 2, 0, 0, 0, 13, 13, 8};
        run_vec(v);

        // start together with clear is dropped
        clear_stats();
        k_i = 2; n_rep_i = 2; start_i = 1'b1; clear_i = 1'b1;
        step();
        start_i = 1'b0; clear_i = 1'b0;
        for (int t = 0; t < 6; t++) step();
        chk("start_clear_busy", busy_seen, 0);
        chk("start_clear_done", done_seen, 0);

        // Reset asserted during DRAIN
        clear_stats();
        push_seq(1, 1);
        k_i = 1; n_rep_i = 1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_quiet("reset_in_drain");
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        clear_stats();
        for (int t = 0; t < 10; t++) step();
        chk("post_reset_done", done_seen, 0);
        chk("post_reset_busy", busy_seen, 0);
        exp_q.delete();

        // start_i in the done cycle is accepted
        clear_stats();
        push_seq(1, 1);
        push_seq(2, 1);
        k_i = 1; n_rep_i = 1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int t = 1; t <= 5; t++) step();
        k_i = 2; n_rep_i = 1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("first_done_t6", done_seen, 1);
        t2 = -1;
        for (int t = 7; t <= 200 && t2 < 0; t++) begin
            step();
            if (done_seen >= 2) t2 = t;
        end
        $display("back-to-back: second done at t=%0d", t2);
        chk("second_done_t", t2, 13);
        chk("b2b_scoreboard", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
